shift_unit_ctrl: RTL and testbench

Multi-cycle sequencer that executes RV64 shift instructions (SLL/SRL/SRA and W variants) on one shared 64-bit logical-right barrel shifter. Left shifts use bit-reversal around the shifter. Arithmetic shifts take a second shifter pass to build the sign-fill mask. Sits in the ALU between issue (valid/ready in) and writeback (valid/ready out).

---
 rtl/shift_pkg.sv | 42 ++++
 rtl/barrel_shifter_right_logical.sv | 24 ++
 rtl/shift_unit_ctrl.sv | 160 ++++++++++++++++
 tb/tb_shift_unit_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift sequencer: opcodes, FSM states, datapath width.
package shift_pkg;

    localparam int XLEN = 64;

    localparam logic [2:0] OP_SLL  = 3'b000;
    localparam logic [2:0] OP_SRL  = 3'b001;
    localparam logic [2:0] OP_SRA  = 3'b010;
    localparam logic [2:0] OP_SLLW = 3'b100;
    localparam logic [2:0] OP_SRLW = 3'b101;
    localparam logic [2:0] OP_SRAW = 3'b110;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_PASS1_ENC = 2'd1;
    localparam logic [1:0] ST_PASS2_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_PASS1 = ST_PASS1_ENC,
        ST_PASS2 = ST_PASS2_ENC,
        ST_DONE  = ST_DONE_ENC
    } state_t;

    // Low two opcode bits select the shift kind; bit 2 selects the W variant.
    function automatic logic op_is_illegal(input logic [2:0] op);
        return op[1:0] == 2'b11;
    endfunction

    function automatic logic op_is_left(input logic [2:0] op);
        return op[1:0] == 2'b00;
    endfunction

    function automatic logic op_is_arith(input logic [2:0] op);
        return op[1:0] == 2'b10;
    endfunction

    function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] value);
        return {{32{value[31]}}, value[31:0]};
    endfunction

endpackage

// File: rtl/barrel_shifter_right_logical.sv
// Combinational 64-bit logical right barrel shifter, one mux stage per shift-amount bit.
module barrel_shifter_right_logical
    import shift_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [5:0]      shamt,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] stage [0:6];

    assign stage[0] = data;

    // Stage gi shifts by 2**gi when the matching shamt bit is set, zero-filling from the top.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_stage
            assign stage[gi+1] = shamt[gi] ? (stage[gi] >> (1 << gi)) : stage[gi];
        end
    endgenerate

    assign result = stage[6];

endmodule

// File: rtl/shift_unit_ctrl.sv
// RV64 shift sequencer: time-shares one logical right shifter across one or two passes.
// Left shifts reverse bits around the shifter; arithmetic shifts use a second pass on
// all-ones to build the sign-fill mask.
module shift_unit_ctrl
    import shift_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_data,
    input  logic [5:0]       in_shamt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    state_t            state_reg;
    logic [2:0]        op_reg;
    logic [XLEN-1:0]   data_reg;
    logic [5:0]        shamt_reg;
    logic [TAG_W-1:0]  tag_reg;

    logic              accept;
    logic [XLEN-1:0]   data_prep;
    logic [5:0]        shamt_prep;
    logic [XLEN-1:0]   data_rev;
    logic [XLEN-1:0]   shift_in;
    logic [XLEN-1:0]   shift_out;
    logic [XLEN-1:0]   shift_out_rev;
    logic [XLEN-1:0]   pass1_value;
    logic [XLEN-1:0]   pass2_value;

    assign in_ready = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Operand preparation: W ops zero- or sign-extend the low word and use a 5-bit amount.
    always_comb begin
        data_prep  = in_data;
        shamt_prep = in_shamt;
        if (in_op[2]) begin
            shamt_prep = {1'b0, in_shamt[4:0]};
            if (op_is_arith(in_op)) begin
                data_prep = sext_word(in_data);
            end else begin
                data_prep = {32'b0, in_data[31:0]};
            end
        end
    end

    // Bit reversal of the operand going in and the shifter output coming back.
    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_rev
            assign data_rev[gi]      = data_reg[XLEN-1-gi];
            assign shift_out_rev[gi] = shift_out[XLEN-1-gi];
        end
    endgenerate

    // Shifter input: operand (reversed for left shifts) in PASS1, all-ones in PASS2.
    always_comb begin
        shift_in = data_reg;
        if (state_reg == ST_PASS2) begin
            shift_in = {XLEN{1'b1}};
        end else if (op_is_left(op_reg)) begin
            shift_in = data_rev;
        end
    end

    barrel_shifter_right_logical u_shifter (
        .data   (shift_in),
        .shamt  (shamt_reg),
        .result (shift_out)
    );

    // PASS1 value is un-reversed for left shifts; PASS2 ORs in the sign-fill mask.
    always_comb begin
        pass1_value = op_is_left(op_reg) ? shift_out_rev : shift_out;
        pass2_value = out_result;
        if (data_reg[XLEN-1]) begin
            pass2_value = out_result | ~shift_out;
        end
    end

    // Sequencer FSM with registered result, tag, error and valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            op_reg     <= 3'b000;
            data_reg   <= '0;
            shamt_reg  <= '0;
            tag_reg    <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_err    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        op_reg    <= in_op;
                        data_reg  <= data_prep;
                        shamt_reg <= shamt_prep;
                        tag_reg   <= in_tag;
                        state_reg <= ST_PASS1;
                    end
                end
                ST_PASS1: begin
                    if (op_is_illegal(op_reg)) begin
                        out_result <= '0;
                        out_err    <= 1'b1;
                        out_tag    <= tag_reg;
                        out_valid  <= 1'b1;
                        state_reg  <= ST_DONE;
                    end else if (op_is_arith(op_reg)) begin
                        out_result <= pass1_value;
                        state_reg  <= ST_PASS2;
                    end else begin
                        out_result <= op_reg[2] ? sext_word(pass1_value) : pass1_value;
                        out_err    <= 1'b0;
                        out_tag    <= tag_reg;
                        out_valid  <= 1'b1;
                        state_reg  <= ST_DONE;
                    end
                end
                ST_PASS2: begin
                    out_result <= op_reg[2] ? sext_word(pass2_value) : pass2_value;
                    out_err    <= 1'b0;
                    out_tag    <= tag_reg;
                    out_valid  <= 1'b1;
                    state_reg  <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (accept) begin
                            op_reg    <= in_op;
                            data_reg  <= data_prep;
                            shamt_reg <= shamt_prep;
                            tag_reg   <= in_tag;
                            state_reg <= ST_PASS1;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit_ctrl.sv
// Directed self-checking bench for shift_unit_ctrl.
module tb_shift_unit_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [63:0] in_data;
    logic [5:0]  in_shamt;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [3:0]  out_tag;
    logic        out_err;

    int total;
    int bad;

    shift_unit_ctrl #(.TAG_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_data    (in_data),
        .in_shamt   (in_shamt),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_err    (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op from IDLE, count edges until out_valid (bounded), capture outputs, drain.
    task automatic issue(input logic [2:0] op, input logic [63:0] data, input logic [5:0] shamt,
                         input logic [3:0] tag, output logic [63:0] res, output logic [3:0] rtag,
                         output logic err, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = data;
        in_shamt = shamt;
        in_tag   = tag;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res  = out_result;
        rtag = out_tag;
        err  = out_err;
        $display("op=%b data=%h shamt=%0d tag=%0d -> result=%h tag=%0d err=%0d latency=%0d",
                 op, data, shamt, tag, res, rtag, err, lat);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_result !== 64'd0 || out_tag !== 4'd0 || out_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b result=%h tag=%h err=%b, want all 0",
                     out_valid, out_result, out_tag, out_err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_srl();
        logic [63:0] r; logic [3:0] t; logic e; int l;
        issue(3'b001, 64'h8000_0000_0000_0000, 6'd63, 4'd1, r, t, e, l);
        total++;
        if (r !== 64'h1 || t !== 4'd1 || e !== 1'b0) begin
            bad++;
            $display("FAIL srl63: got result=%h tag=%0d err=%b, want 1 tag=1 err=0", r, t, e);
        end
        total++;
        if (l !== 2) begin
            bad++;
            $display("FAIL srl_latency: got %0d want 2", l);
        end
    endtask

    task automatic test_sll();
        logic [63:0] r; logic [3:0] t; logic e; int l;
        issue(3'b000, 64'h1, 6'd63, 4'd2, r, t, e, l);
        total++;
        if (r !== 64'h8000_0000_0000_0000 || l !== 2) begin
            bad++;
            $display("FAIL sll63: got result=%h lat=%0d, want 8000000000000000 lat=2", r, l);
        end
        issue(3'b000, 64'h1234, 6'd0, 4'd3, r, t, e, l);
        total++;
        if (r !== 64'h1234 || t !== 4'd3) begin
            bad++;
            $display("FAIL sll0: got result=%h tag=%0d, want 1234 tag=3", r, t);
        end
    endtask

    task automatic test_sra();
        logic [63:0] r; logic [3:0] t; logic e; int l;
        issue(3'b010, 64'hF000_0000_0000_0000, 6'd4, 4'd4, r, t, e, l);
        total++;
        if (r !== 64'hFF00_0000_0000_0000 || e !== 1'b0) begin
            bad++;
            $display("FAIL sra_neg: got result=%h err=%b, want ff00000000000000 err=0", r, e);
        end
        total++;
        if (l !== 3) begin
            bad++;
            $display("FAIL sra_latency: got %0d want 3", l);
        end
        issue(3'b010, 64'h7000_0000_0000_0000, 6'd4, 4'd5, r, t, e, l);
        total++;
        if (r !== 64'h0700_0000_0000_0000) begin
            bad++;
            $display("FAIL sra_pos: got %h want 0700000000000000", r);
        end
        issue(3'b010, 64'h8000_0000_0000_0001, 6'd0, 4'd6, r, t, e, l);
        total++;
        if (r !== 64'h8000_0000_0000_0001) begin
            bad++;
            $display("FAIL sra0: got %h want 8000000000000001", r);
        end
    endtask

    task automatic test_word_ops();
        logic [63:0] r; logic [3:0] t; logic e; int l;
        issue(3'b110, 64'h0000_0000_8000_0000, 6'h3F, 4'd7, r, t, e, l);
        total++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF || l !== 3) begin
            bad++;
            $display("FAIL sraw: got result=%h lat=%0d, want ffffffffffffffff lat=3", r, l);
        end
        issue(3'b101, 64'h0000_0000_8000_0000, 6'h3F, 4'd8, r, t, e, l);
        total++;
        if (r !== 64'h1 || l !== 2) begin
            bad++;
            $display("FAIL srlw: got result=%h lat=%0d, want 1 lat=2", r, l);
        end
        issue(3'b100, 64'h1, 6'd31, 4'd9, r, t, e, l);
        total++;
        if (r !== 64'hFFFF_FFFF_8000_0000) begin
            bad++;
            $display("FAIL sllw: got %h want ffffffff80000000", r);
        end
        issue(3'b101, 64'hDEAD_BEEF_1234_5678, 6'd0, 4'd10, r, t, e, l);
        total++;
        if (r !== 64'h0000_0000_1234_5678) begin
            bad++;
            $display("FAIL srlw0: got %h want 0000000012345678", r);
        end
    endtask

    task automatic test_illegal();
        logic [63:0] r; logic [3:0] t; logic e; int l;
        issue(3'b011, 64'hFFFF_0000_FFFF_0000, 6'd3, 4'd5, r, t, e, l);
        total++;
        if (e !== 1'b1 || r !== 64'd0 || t !== 4'd5 || l !== 2) begin
            bad++;
            $display("FAIL illegal011: got err=%b result=%h tag=%0d lat=%0d, want 1 0 5 2", e, r, t, l);
        end
        issue(3'b111, 64'h1, 6'd1, 4'd12, r, t, e, l);
        total++;
        if (e !== 1'b1 || r !== 64'd0 || t !== 4'd12) begin
            bad++;
            $display("FAIL illegal111: got err=%b result=%h tag=%0d, want 1 0 12", e, r, t);
        end
        issue(3'b001, 64'h10, 6'd4, 4'd13, r, t, e, l);
        total++;
        if (e !== 1'b0 || r !== 64'h1) begin
            bad++;
            $display("FAIL err_clear: got err=%b result=%h, want 0 1", e, r);
        end
    endtask

    task automatic test_back_to_back();
        int l;
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'b001; in_data = 64'hF0; in_shamt = 6'd4; in_tag = 4'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        l = 1;
        while (!out_valid && l < 8) begin
            @(posedge clk);
            #1;
            l++;
        end
        total++;
        if (out_valid !== 1'b1 || out_result !== 64'hF) begin
            bad++;
            $display("FAIL bp_first: got valid=%b result=%h, want 1 f", out_valid, out_result);
        end
        // Hold backpressure for five cycles; result, tag and in_ready must not move.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_op = 3'b000; in_data = 64'h3; in_shamt = 6'd2; in_tag = 4'd2;
            total++;
            if (out_valid !== 1'b1 || out_result !== 64'hF || out_tag !== 4'd1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d: got valid=%b result=%h tag=%0d in_ready=%b, want 1 f 1 0",
                         i, out_valid, out_result, out_tag, in_ready);
            end
        end
        $display("backpressure held 5 cycles, tag=%0d", out_tag);
        // Release: same-edge consume and accept of the next op.
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_in_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_pass1: got valid=%b in_ready=%b, want 0 0", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1 || out_result !== 64'hC || out_tag !== 4'd2) begin
            bad++;
            $display("FAIL b2b_second: got valid=%b result=%h tag=%0d, want 1 c 2",
                     out_valid, out_result, out_tag);
        end
        $display("back-to-back second result=%h tag=%0d", out_result, out_tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'b010; in_data = 64'hF000_0000_0000_0000; in_shamt = 6'd4; in_tag = 4'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_result !== 64'd0 || out_tag !== 4'd0 || out_err !== 1'b0) begin
            bad++;
            $display("FAIL midreset_outputs: got valid=%b result=%h tag=%0d err=%b, want all 0",
                     out_valid, out_result, out_tag, out_err);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_idle: got in_ready=%b valid=%b, want 1 0", in_ready, out_valid);
        end
        $display("reset during SRA pass2: outputs cleared, idle");
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        in_valid = 1'b0;
        in_op = 3'b000;
        in_data = 64'd0;
        in_shamt = 6'd0;
        in_tag = 4'd0;
        out_ready = 1'b0;
        test_reset();
        test_srl();
        test_sll();
        test_sra();
        test_word_ops();
        test_illegal();
        test_back_to_back();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
